// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR hex display: seven-segment glyphs, default
// feedback masks and the per-cycle controller action.
package lfsr_pkg;

    // Segment byte layout: bit7..bit1 = a..g, bit0 = dp; active-low, dp off.
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'h63, 8'h85, 8'h61, 8'h71
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Mask bit i selects term x^i; x^WIDTH is implied.
    localparam logic [3:0]  TAPS_W4  = 4'h3;
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'hA011;
    localparam logic [31:0] TAPS_W32 = 32'h0040_0007;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_RESET,
        ACT_LOAD,
        ACT_ADV
    } lfsr_act_e;

    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            4:       default_taps = 32'(TAPS_W4);
            16:      default_taps = 32'(TAPS_W16);
            32:      default_taps = TAPS_W32;
            default: default_taps = 32'(TAPS_W8);
        endcase
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Registered hex-to-seven-segment decoder; synchronous reset loads a
// caller-chosen glyph so the display matches the reset state immediately.
module hex7seg
    import lfsr_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rst_val,
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    logic [7:0] r_seg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= i_rst_val;
        end else begin
            r_seg <= SEG_HEX[i_nibble];
        end
    end

    assign o_seg = r_seg;

endmodule

// File: rtl/lfsr_hexdisp.sv
// Fibonacci LFSR with run/step/load control, period-wrap flag and a
// registered seven-segment readout of every state nibble.
module lfsr_hexdisp
    import lfsr_pkg::*;
#(
    parameter int unsigned             WIDTH = 8,
    parameter logic [WIDTH-1:0]        TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter int unsigned             DIV   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 step,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed,
    output logic [WIDTH-1:0]     state,
    output logic [2*WIDTH-1:0]   seg,
    output logic                 wrap
);

    localparam int unsigned      DIGITS  = WIDTH / 4;
    localparam int unsigned      PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             r_step_q;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic             r_wrap;

    logic             w_pre_tc;
    logic             w_step_rise;
    logic             w_adv;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_safe;
    lfsr_act_e        w_act;

    assign w_pre_tc    = (r_pre == PRE_MAX);
    assign w_step_rise = step & ~r_step_q;
    assign w_adv       = (en & w_pre_tc) | w_step_rise;
    assign w_next      = {^(r_state & TAPS), r_state[WIDTH-1:1]};
    assign w_seed_safe = (seed == '0) ? WIDTH'(1) : seed;

    always_comb begin
        w_act = ACT_HOLD;
        if (rst) begin
            w_act = ACT_RESET;
        end else if (load) begin
            w_act = ACT_LOAD;
        end else if (w_adv) begin
            w_act = ACT_ADV;
        end
    end

    // Load restarts the prescale window so the next run advance is DIV cycles out.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_pre_tc ? '0 : r_pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end

    always_ff @(posedge clk) begin
        unique case (w_act)
            ACT_RESET: begin
                r_state <= WIDTH'(1);
                r_start <= WIDTH'(1);
                r_wrap  <= 1'b0;
            end
            ACT_LOAD: begin
                r_state <= w_seed_safe;
                r_start <= w_seed_safe;
                r_wrap  <= 1'b0;
            end
            ACT_ADV: begin
                r_state <= w_next;
                r_wrap  <= (w_next == r_start);
            end
            default: begin
                r_wrap  <= 1'b0;
            end
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [3:0] RST_NIB = (g == 0) ? 4'h1 : 4'h0;

        hex7seg u_hex7seg (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_rst_val (SEG_HEX[RST_NIB]),
            .i_nibble  (r_state[4*g +: 4]),
            .o_seg     (seg[8*g +: 8])
        );
    end

    assign state = r_state;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_lfsr_hexdisp.sv
// Bench for lfsr_hexdisp: a DIV=1 and a DIV=4 instance share stimulus and are
// compared every cycle against a sequence-position model plus directed checks.
module tb_lfsr_hexdisp;

    logic        clk;
    logic        rst;
    logic        en;
    logic        step;
    logic        load;
    logic [7:0]  seed;

    logic [7:0]  st0, st1;
    logic [15:0] sg0, sg1;
    logic        wr0, wr1;

    int total = 0;
    int bad   = 0;

    lfsr_hexdisp #(.WIDTH(8), .TAPS(8'h1D), .DIV(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .en(en), .step(step), .load(load),
        .seed(seed), .state(st0), .seg(sg0), .wrap(wr0)
    );

    lfsr_hexdisp #(.WIDTH(8), .TAPS(8'h1D), .DIV(4)) u_dut_d4 (
        .clk(clk), .rst(rst), .en(en), .step(step), .load(load),
        .seed(seed), .state(st1), .seg(sg1), .wrap(wr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lit segments per hex digit, by segment letter.
    string GL [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    logic [7:0] seq [255];
    int         pos_of [256];
    int         DIVV [2] = '{1, 4};

    int          m_p     [2];
    int          m_start [2];
    int          m_cnt   [2];
    logic        m_wrap  [2];
    logic [15:0] m_seg   [2];
    logic        m_stepq;
    int          wraps0;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] r;
        string      s;
        int         idx;
        r = 8'hFF;
        s = GL[n];
        for (int k = 0; k < s.len(); k++) begin
            idx = 7 - (int'(s[k]) - 97);
            r[idx] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [15:0] disp(input logic [7:0] v);
        return {glyph(v[7:4]), glyph(v[3:0])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [7:0] prev;
        logic       rise;
        logic       run;
        @(posedge clk);
        #1;
        rise = step && !m_stepq;
        for (int i = 0; i < 2; i++) begin
            prev = seq[m_p[i]];
            if (rst) begin
                m_p[i]     = 0;
                m_start[i] = 0;
                m_cnt[i]   = 0;
                m_wrap[i]  = 1'b0;
                m_seg[i]   = disp(8'h01);
            end else begin
                m_seg[i] = disp(prev);
                run = en && (m_cnt[i] == DIVV[i] - 1);
                if (en) m_cnt[i] = (m_cnt[i] + 1) % DIVV[i];
                if (load) begin
                    m_p[i]     = pos_of[(seed == 8'h00) ? 1 : int'(seed)];
                    m_start[i] = m_p[i];
                    m_cnt[i]   = 0;
                    m_wrap[i]  = 1'b0;
                end else if (run || rise) begin
                    m_p[i]    = (m_p[i] + 1) % 255;
                    m_wrap[i] = (m_p[i] == m_start[i]);
                end else begin
                    m_wrap[i] = 1'b0;
                end
            end
        end
        m_stepq = rst ? 1'b0 : step;
        if (wr0 === 1'b1) wraps0++;
        chk("m_state_d1", 32'(st0), 32'(seq[m_p[0]]));
        chk("m_wrap_d1",  32'(wr0), 32'(m_wrap[0]));
        chk("m_seg_d1",   32'(sg0), 32'(m_seg[0]));
        chk("m_state_d4", 32'(st1), 32'(seq[m_p[1]]));
        chk("m_wrap_d4",  32'(wr1), 32'(m_wrap[1]));
        chk("m_seg_d4",   32'(sg1), 32'(m_seg[1]));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] run_exp [5];
        int         zeros;

        v = 8'h01;
        for (int k = 0; k < 255; k++) begin
            seq[k] = v;
            pos_of[v] = k;
            v = {^(v & 8'h1D), v[7:1]};
        end
        pos_of[0] = 0;
        run_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        m_stepq = 1'b0;

        rst = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0; seed = 8'h00;

        // Reset values
        cycle();
        cycle();
        chk("rst_state", 32'(st0), 32'h01);
        chk("rst_wrap",  32'(wr0), 32'h0);
        chk("rst_seg",   32'(sg0), 32'h039F);

        // Free run, DIV=1: sequence and a single wrap at 255 advances
        rst = 1'b0; en = 1'b1;
        wraps0 = 0;
        for (int k = 1; k <= 255; k++) begin
            cycle();
            if (k <= 5) chk("run_seq", 32'(st0), 32'(run_exp[k-1]));
        end
        chk("wrap_count", 32'(wraps0), 32'd1);
        chk("wrap_state", 32'(st0), 32'h01);
        chk("wrap_pulse", 32'(wr0), 32'h1);

        // Reset mid-run at 88
        repeat (5) cycle();
        chk("pre_rst_state", 32'(st0), 32'h88);
        rst = 1'b1;
        cycle();
        chk("midrst_state", 32'(st0), 32'h01);
        chk("midrst_wrap",  32'(wr0), 32'h0);
        rst = 1'b0; en = 1'b0;
        cycle();
        chk("midrst_seg", 32'(sg0), 32'h039F);

        // Load A5, readout, wrap after 255 advances
        load = 1'b1; seed = 8'hA5;
        cycle();
        load = 1'b0;
        chk("load_state", 32'(st0), 32'hA5);
        cycle();
        chk("load_seg", 32'(sg0), 32'h1149);
        en = 1'b1;
        wraps0 = 0;
        repeat (255) cycle();
        chk("load_wrap_count", 32'(wraps0), 32'd1);
        chk("load_wrap_state", 32'(st0), 32'hA5);

        // Zero seed guard, no lock-up
        en = 1'b0; load = 1'b1; seed = 8'h00;
        cycle();
        load = 1'b0;
        chk("zero_seed", 32'(st0), 32'h01);
        en = 1'b1;
        zeros = 0;
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (st0 == 8'h00 || st1 == 8'h00) zeros++;
        end
        chk("no_lockup", 32'(zeros), 32'd0);

        // Step edge detection
        en = 1'b0; load = 1'b1; seed = 8'h01;
        cycle();
        load = 1'b0; step = 1'b1;
        repeat (5) cycle();
        step = 1'b0;
        cycle();
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        chk("step_d1", 32'(st0), 32'h40);
        chk("step_d4", 32'(st1), 32'h40);

        // DIV=4: load beats run and step, prescaler restarts
        en = 1'b1;
        repeat (2) cycle();
        load = 1'b1; seed = 8'h37; step = 1'b1;
        cycle();
        load = 1'b0;
        chk("ldprio_d4", 32'(st1), 32'h37);
        chk("ldprio_d1", 32'(st0), 32'h37);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("ldprio_hold_d4", 32'(st1), 32'h37);
        end
        cycle();
        chk("ldprio_adv_d4", 32'(st1), 32'h9B);
        step = 1'b0;

        // Randomized mix
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom % 64) == 0;
            load = ($urandom % 16) == 0;
            en   = ($urandom % 4) != 0;
            step = ($urandom % 3) == 0;
            seed = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
